// File: rtl/apu_pulse_bank_gen3_if.sv
// Bus bundle for apu_pulse_bank_gen3: frame-sequencer strobes, CPU register window,
// $4015 enables and the per-channel sample/active outputs.
interface apu_pulse_bank_gen3_if #(
    parameter int unsigned NUM_CH = 2
);
    localparam int unsigned AW = $clog2(NUM_CH) + 2;

    logic                  apu_clk;
    logic                  l_pulse;
    logic                  e_pulse;
    logic                  wren;
    logic [AW-1:0]         addr;
    logic [7:0]            from_cpu;
    logic [NUM_CH-1:0]     ch_en;
    logic [4*NUM_CH-1:0]   pulse_out;
    logic [NUM_CH-1:0]     active_out;

    modport master (
        output apu_clk, l_pulse, e_pulse, wren, addr, from_cpu, ch_en,
        input  pulse_out, active_out
    );

    modport slave (
        input  apu_clk, l_pulse, e_pulse, wren, addr, from_cpu, ch_en,
        output pulse_out, active_out
    );
endinterface

// File: rtl/apu_pulse_bank_gen3.sv
// Bank of NUM_CH 2A03-style pulse channels sharing one register window and frame sequencer.
// Define APU_PULSE_SWEEP_EN to build the per-channel sweep units.
module apu_pulse_bank_gen3 #(
    parameter int unsigned NUM_CH        = 2,
    parameter logic [7:0]  NEG_ONES_MASK = 8'h01,
    parameter int unsigned MIN_PERIOD    = 8
) (
    input logic                  clk,
    input logic                  rst,
    apu_pulse_bank_gen3_if.slave bus
);
    localparam logic [7:0] LEN_TBL [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
        8'd160, 8'd8,   8'd60,  8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
        8'd12,  8'd16,  8'd24,  8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
        8'd192, 8'd24,  8'd72,  8'd26, 8'd16, 8'd28, 8'd32, 8'd30
    };

    // Upper address bits pick the channel; out-of-range channels simply never match.
    logic [31:0] ch_sel;
    assign ch_sel = 32'(bus.addr) >> 2;

    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        logic [1:0]  duty;
        logic        halt;
        logic        cnst;
        logic [3:0]  vol;
        logic [10:0] period;
        logic [10:0] timer;
        logic [2:0]  step;
        logic [7:0]  length;
        logic        env_start;
        logic [3:0]  env_div;
        logic [3:0]  decay;
        logic [3:0]  level;
        logic [7:0]  pattern;
        logic        sweep_mute;
        logic        wr_hit;

        assign wr_hit = bus.wren && (ch_sel == 32'(i));

        // Duty pattern indexed by sequencer step (bit n = step n).
        always_comb begin
            pattern = 8'b0000_0010;
            case (duty)
                2'd0:    pattern = 8'b0000_0010;
                2'd1:    pattern = 8'b0000_0110;
                2'd2:    pattern = 8'b0001_1110;
                default: pattern = 8'b1111_1001;
            endcase
        end

`ifdef APU_PULSE_SWEEP_EN
        logic        sw_en;
        logic        sw_neg;
        logic        sw_reload;
        logic [2:0]  sw_div_cfg;
        logic [2:0]  sw_shift;
        logic [2:0]  sw_div;
        logic [11:0] shifted;
        logic [11:0] target;

        // Sweep target and mute; channel-specific negate flavour comes from NEG_ONES_MASK.
        always_comb begin
            shifted = 12'(period >> sw_shift);
            if (sw_neg)
                target = 12'(period) - shifted - (NEG_ONES_MASK[i] ? 12'd1 : 12'd0);
            else
                target = 12'(period) + shifted;
            sweep_mute = (!sw_neg && (target > 12'h7FF)) || (period < 11'(MIN_PERIOD));
        end
`else
        assign sweep_mute = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                duty      <= 2'd0;
                halt      <= 1'b0;
                cnst      <= 1'b0;
                vol       <= 4'd0;
                period    <= 11'd0;
                timer     <= 11'd0;
                step      <= 3'd0;
                length    <= 8'd0;
                env_start <= 1'b0;
                env_div   <= 4'd0;
                decay     <= 4'd0;
                level     <= 4'd0;
`ifdef APU_PULSE_SWEEP_EN
                sw_en      <= 1'b0;
                sw_neg     <= 1'b0;
                sw_reload  <= 1'b0;
                sw_div_cfg <= 3'd0;
                sw_shift   <= 3'd0;
                sw_div     <= 3'd0;
`endif
            end else begin
                if (bus.apu_clk) begin
                    if (timer == 11'd0) begin
                        timer <= period;
                        step  <= step - 3'd1;
                    end else begin
                        timer <= timer - 11'd1;
                    end
                end

                if (bus.e_pulse) begin
                    if (env_start) begin
                        env_start <= 1'b0;
                        decay     <= 4'd15;
                        env_div   <= vol;
                    end else if (env_div == 4'd0) begin
                        env_div <= vol;
                        if (decay != 4'd0)
                            decay <= decay - 4'd1;
                        else if (halt)
                            decay <= 4'd15;
                    end else begin
                        env_div <= env_div - 4'd1;
                    end
                end

                if (bus.l_pulse && (length != 8'd0) && !halt)
                    length <= length - 8'd1;

`ifdef APU_PULSE_SWEEP_EN
                if (bus.l_pulse) begin
                    if ((sw_div == 3'd0) && sw_en && (sw_shift != 3'd0) && !sweep_mute)
                        period <= target[10:0];
                    if ((sw_div == 3'd0) || sw_reload) begin
                        sw_div    <= sw_div_cfg;
                        sw_reload <= 1'b0;
                    end else begin
                        sw_div <= sw_div - 3'd1;
                    end
                end
`endif

                // Register writes come last so a coincident write overrides the frame-driven update.
                if (wr_hit) begin
                    case (bus.addr[1:0])
                        2'd0: {duty, halt, cnst, vol} <= bus.from_cpu;
`ifdef APU_PULSE_SWEEP_EN
                        2'd1: begin
                            {sw_en, sw_div_cfg, sw_neg, sw_shift} <= bus.from_cpu;
                            sw_reload <= 1'b1;
                        end
`endif
                        2'd2: period[7:0] <= bus.from_cpu;
                        2'd3: begin
                            period[10:8] <= bus.from_cpu[2:0];
                            step         <= 3'd0;
                            env_start    <= 1'b1;
                            if (bus.ch_en[i])
                                length <= LEN_TBL[bus.from_cpu[7:3]];
                        end
                        default: ;
                    endcase
                end

                if (!bus.ch_en[i])
                    length <= 8'd0;

                if ((length == 8'd0) || (period < 11'(MIN_PERIOD)) || !pattern[step] || sweep_mute)
                    level <= 4'd0;
                else
                    level <= cnst ? vol : decay;
            end
        end

        assign bus.pulse_out[4*i +: 4] = level;
        assign bus.active_out[i]       = (length != 8'd0);
    end
endmodule
